// File: rtl/axis_rx_packer_8to64.sv
// axis_rx_packer_8to64
// Packs the 8-bit AXI4-Stream RX byte stream of a 1G port into 64-bit beats.
// Byte lane 0 ([7:0]) holds the first byte of each beat. A beat closes after
// 8 accepted bytes or on the tlast byte. A bad-frame flag travels as tuser[0]
// on the last beat of the frame.
//
// Optional feature: define AXIS_RX_PACKER_STATS_EN to add saturating
// frame_count / err_frame_count outputs. The datapath is the same either way.
//
// Ports
//   clk, reset          stream clock, synchronous active-high reset
//   s_axis_*            8-bit input stream (tdata, tstrb, tvalid, tready, tlast, err_tvalid)
//   m_axis_*            64-bit output stream (tdata, tstrb, tvalid, tready, tlast, tuser)
//   frame_count         accepted frames, saturating (STATS_EN only)
//   err_frame_count     accepted bad frames, saturating (STATS_EN only)
module axis_rx_packer_8to64 #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH = 8,
  parameter int unsigned C_M_AXIS_DATA_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                             s_axis_tstrb,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic                             s_axis_err_tvalid,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tuser
`ifdef AXIS_RX_PACKER_STATS_EN
  ,
  output logic [31:0]                      frame_count,
  output logic [31:0]                      err_frame_count
`endif
);

  localparam int unsigned LANES  = C_M_AXIS_DATA_WIDTH / C_S_AXIS_DATA_WIDTH;
  localparam int unsigned IDX_W  = $clog2(LANES);
  localparam int unsigned STRB_W = C_M_AXIS_DATA_WIDTH / 8;

  // Accumulator and output register
  logic [C_M_AXIS_DATA_WIDTH-1:0] r_acc_data;
  logic [STRB_W-1:0]              r_acc_strb;
  logic [IDX_W-1:0]               r_idx;
  logic [C_M_AXIS_DATA_WIDTH-1:0] r_out_data;
  logic [STRB_W-1:0]              r_out_strb;
  logic                           r_out_valid;
  logic                           r_out_last;
  logic                           r_out_user;

  logic                           w_out_free;
  logic                           w_last_lane;
  logic                           w_accept;
  logic                           w_close;
  logic [C_M_AXIS_DATA_WIDTH-1:0] w_acc_data_nxt;
  logic [STRB_W-1:0]              w_acc_strb_nxt;

  assign w_last_lane = (r_idx == IDX_W'(LANES - 1));
  assign w_out_free  = ~r_out_valid | m_axis_tready;
  // Only a closing byte needs the output register; all others are always taken.
  assign s_axis_tready = w_out_free | (~w_last_lane & ~s_axis_tlast);
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_close       = w_accept & (w_last_lane | s_axis_tlast);

  // Accumulator with the current byte merged into lane r_idx (tstrb=0 writes nothing)
  always_comb begin
    w_acc_data_nxt = r_acc_data;
    w_acc_strb_nxt = r_acc_strb;
    if (s_axis_tstrb) begin
      w_acc_data_nxt[int'(r_idx)*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH] = s_axis_tdata;
      w_acc_strb_nxt[r_idx] = 1'b1;
    end
  end

  // Packing datapath and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_data  <= '0;
      r_acc_strb  <= '0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_strb  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_user  <= 1'b0;
    end else if (w_close) begin
      // Close implies the output register is free (empty or draining this cycle).
      r_out_data  <= w_acc_data_nxt;
      r_out_strb  <= w_acc_strb_nxt;
      r_out_valid <= 1'b1;
      r_out_last  <= s_axis_tlast;
      r_out_user  <= s_axis_tlast & s_axis_err_tvalid;
      r_acc_data  <= '0;
      r_acc_strb  <= '0;
      r_idx       <= '0;
    end else begin
      if (w_accept) begin
        r_acc_data <= w_acc_data_nxt;
        r_acc_strb <= w_acc_strb_nxt;
        r_idx      <= r_idx + IDX_W'(1);
      end
      if (m_axis_tready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_out_user  <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_out_data;
  assign m_axis_tstrb  = r_out_strb;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tlast  = r_out_last;
  assign m_axis_tuser  = r_out_user;

`ifdef AXIS_RX_PACKER_STATS_EN
  logic [31:0] r_frame_count;
  logic [31:0] r_err_frame_count;
  logic        w_frame_end;

  assign w_frame_end = w_accept & s_axis_tlast;

  // Saturating frame statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_count     <= '0;
      r_err_frame_count <= '0;
    end else if (w_frame_end) begin
      if (r_frame_count != '1) begin
        r_frame_count <= r_frame_count + 32'd1;
      end
      if (s_axis_err_tvalid && (r_err_frame_count != '1)) begin
        r_err_frame_count <= r_err_frame_count + 32'd1;
      end
    end
  end

  assign frame_count     = r_frame_count;
  assign err_frame_count = r_err_frame_count;
`endif

endmodule
